// File: rtl/vr_hw3_seq_alu.sv
// Registered W-bit ALU (AND/OR/ADD/SUB/SLT plus multi-cycle shift-add MUL) with a start/done handshake.
// Optional Overflow output is enabled by defining SEQ_ALU_OVF_EN.
module vr_hw3_seq_alu #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   ALUCtrl,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] ALUOut,
`ifdef SEQ_ALU_OVF_EN
  output logic         Zero,
  output logic         Overflow
`else
  output logic         Zero
`endif
);

  localparam int CNTW = $clog2(W) + 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [W-1:0]    acc;
  logic [W-1:0]    mcand;
  logic [W-1:0]    mplier;

  logic [W-1:0]    add_a;
  logic [W-1:0]    add_b;
  logic            add_cin;
  logic [W-1:0]    sum;
  logic            s_ovf;
  logic            slt_bit;
  logic [W-1:0]    op_result;

  assign busy = (state != S_IDLE);

  // One adder serves ADD/SUB/SLT in IDLE and the acc += mcand step while multiplying.
  always_comb begin
    add_a   = A;
    add_b   = B;
    add_cin = 1'b0;
    if (state == S_MUL) begin
      add_a = acc;
      add_b = mplier[0] ? mcand : '0;
    end else if (ALUCtrl == OP_SUB || ALUCtrl == OP_SLT) begin
      add_b   = ~B;
      add_cin = 1'b1;
    end
  end

`ifdef SEQ_ALU_OVF_EN
  logic         carry;
  logic [W-1:0] mcand_hi;
  logic [W-1:0] acc_hi;
  logic [W-1:0] hi_sum;
  logic         op_ovf;

  assign {carry, sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  // Upper half of the 2W-bit product, fed by the low adder's carry.
  assign hi_sum = acc_hi + (mplier[0] ? mcand_hi : '0) + {{(W-1){1'b0}}, carry};

  always_comb begin
    op_ovf = 1'b0;
    if (ALUCtrl == OP_ADD || ALUCtrl == OP_SUB) begin
      op_ovf = s_ovf;
    end
  end
`else
  assign sum = add_a + add_b + {{(W-1){1'b0}}, add_cin};
`endif

  assign s_ovf   = (add_a[W-1] == add_b[W-1]) && (sum[W-1] != add_a[W-1]);
  assign slt_bit = sum[W-1] ^ s_ovf;

  always_comb begin
    op_result = '0;
    case (ALUCtrl)
      OP_AND:         op_result = A & B;
      OP_OR:          op_result = A | B;
      OP_ADD, OP_SUB: op_result = sum;
      OP_SLT:         op_result = {{(W-1){1'b0}}, slt_bit};
      default:        op_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      done     <= 1'b0;
      ALUOut   <= '0;
      Zero     <= 1'b1;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
`ifdef SEQ_ALU_OVF_EN
      Overflow <= 1'b0;
      acc_hi   <= '0;
      mcand_hi <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (ALUCtrl == OP_MUL) begin
              mcand  <= A;
              mplier <= B;
              acc    <= '0;
              cnt    <= CNTW'(W);
              state  <= S_MUL;
`ifdef SEQ_ALU_OVF_EN
              acc_hi   <= '0;
              mcand_hi <= '0;
`endif
            end else begin
              ALUOut <= op_result;
              Zero   <= (op_result == '0);
              done   <= 1'b1;
              state  <= S_DONE;
`ifdef SEQ_ALU_OVF_EN
              Overflow <= op_ovf;
`endif
            end
          end
        end
        S_MUL: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNTW'(1);
`ifdef SEQ_ALU_OVF_EN
          acc_hi   <= hi_sum;
          mcand_hi <= {mcand_hi[W-2:0], mcand[W-1]};
`endif
          // Last iteration: the adder output is already the final product.
          if (cnt == CNTW'(1)) begin
            ALUOut <= sum;
            Zero   <= (sum == '0);
            done   <= 1'b1;
            state  <= S_DONE;
`ifdef SEQ_ALU_OVF_EN
            Overflow <= (hi_sum != '0);
`endif
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vr_hw3_seq_alu.sv
// Bench for vr_hw3_seq_alu (W=32): directed vector table, hand-written multi-cycle sequences
// and randomized operations compared against an arithmetic reference model.
module tb_vr_hw3_seq_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] alu_out;
  logic         zero;
`ifdef SEQ_ALU_OVF_EN
  logic         overflow;
`endif

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  vr_hw3_seq_alu #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ALUCtrl (alu_ctrl),
    .A       (a),
    .B       (b),
    .busy    (busy),
    .done    (done),
    .ALUOut  (alu_out),
`ifdef SEQ_ALU_OVF_EN
    .Zero    (zero),
    .Overflow(overflow)
`else
    .Zero    (zero)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operation's meaning.
  function automatic logic [31:0] modelResult(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = {32'b0, x} * {32'b0, y};
    case (op)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b111:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'b011:  return p[31:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic modelOverflow(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint s;
    logic [63:0] p;
    p = {32'b0, x} * {32'b0, y};
    case (op)
      3'b010: begin
        s = longint'($signed(x)) + longint'($signed(y));
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b110: begin
        s = longint'($signed(x)) - longint'($signed(y));
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b011:  return p[63:32] != 32'd0;
      default: return 1'b0;
    endcase
  endfunction

  // Waits for IDLE, issues one start, then counts cycles until done (bounded).
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                               output int latency, output int done_cycle);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    start    = 1'b1;
    alu_ctrl = op;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    latency = 1;
    while (!done && latency < 100) begin
      @(posedge clk);
      #1;
      latency++;
    end
    done_cycle = cycle;
    if (!done) latency = -1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp_res, input logic exp_ovf,
                             input int exp_lat, input int latency);
    check({name, " latency"}, 64'(latency), 64'(exp_lat));
    check({name, " result"}, {32'b0, alu_out}, {32'b0, exp_res});
    check({name, " zero"}, {63'b0, zero}, {63'b0, exp_res == 32'd0});
`ifdef SEQ_ALU_OVF_EN
    check({name, " overflow"}, {63'b0, overflow}, {63'b0, exp_ovf});
`else
    if (exp_ovf === 1'bx) $display("[TB] note: unknown overflow expectation");
`endif
    @(posedge clk);
    #1;
    check({name, " done pulse width"}, {63'b0, done}, 64'd0);
    check({name, " result hold"}, {32'b0, alu_out}, {32'b0, exp_res});
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return $urandom_range(0, 15);
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int dcyc;
    int dcyc2;
    int busy_cnt;
    int done_cnt;
    logic [2:0] ops[8];
    logic [2:0] op;
    logic [31:0] x;
    logic [31:0] y;

    ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};

    vecs.push_back('{"add 7+5",        3'b010, 32'd7,         32'd5,         32'd12,        1'b0});
    vecs.push_back('{"add wrap",       3'b010, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0});
    vecs.push_back('{"add sovf",       3'b010, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b1});
    vecs.push_back('{"sub 5-5",        3'b110, 32'd5,         32'd5,         32'd0,         1'b0});
    vecs.push_back('{"sub sovf",       3'b110, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1});
    vecs.push_back('{"slt -1<1",       3'b111, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0});
    vecs.push_back('{"slt 1<-1",       3'b111, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0});
    vecs.push_back('{"slt min<max",    3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1,         1'b0});
    vecs.push_back('{"slt max<min",    3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         1'b0});
    vecs.push_back('{"and",            3'b000, 32'hF0,        32'h3C,        32'h30,        1'b0});
    vecs.push_back('{"or",             3'b001, 32'hF0,        32'h3C,        32'hFC,        1'b0});
    vecs.push_back('{"undef 100",      3'b100, 32'hFFFF,      32'd1,         32'd0,         1'b0});
    vecs.push_back('{"undef 101",      3'b101, 32'd3,         32'd3,         32'd0,         1'b0});
    vecs.push_back('{"mul 12*11",      3'b011, 32'd12,        32'd11,        32'd132,       1'b0});
    vecs.push_back('{"mul 2^32",       3'b011, 32'h1_0000,    32'h1_0000,    32'd0,         1'b1});
    vecs.push_back('{"mul -1*-1",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b1});
    vecs.push_back('{"mul 3*max",      3'b011, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1});
    vecs.push_back('{"mul 0*5",        3'b011, 32'd0,         32'd5,         32'd0,         1'b0});

    rst = 1'b1; start = 1'b0; alu_ctrl = 3'b000; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset busy", {63'b0, busy}, 64'd0);
    check("reset done", {63'b0, done}, 64'd0);
    check("reset result", {32'b0, alu_out}, 64'd0);
    check("reset zero", {63'b0, zero}, 64'd1);
`ifdef SEQ_ALU_OVF_EN
    check("reset overflow", {63'b0, overflow}, 64'd0);
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, dcyc);
      checkOutput(vecs[i].name, vecs[i].exp_res, vecs[i].exp_ovf,
                  (vecs[i].op == 3'b011) ? W + 1 : 1, lat);
    end

    // MUL with stray start pulses while busy; busy must last W+1 cycles.
    @(negedge clk);
    start = 1'b1; alu_ctrl = 3'b011; a = 32'd12; b = 32'd11;
    @(posedge clk);
    #1;
    busy_cnt = 0;
    lat = 0;
    while (busy && busy_cnt < 100) begin
      busy_cnt++;
      if (done && lat == 0) lat = busy_cnt;
      @(negedge clk);
      start    = (lat == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      alu_ctrl = 3'b010;
      a        = $urandom;
      b        = $urandom;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("mul busy cycles", 64'(busy_cnt), 64'(W + 1));
    check("mul done latency", 64'(lat), 64'(W + 1));
    check("mul ignoring starts", {32'b0, alu_out}, 64'd132);

    // Reset in the middle of a MUL abandons it without a done pulse.
    @(negedge clk);
    start = 1'b1; alu_ctrl = 3'b011; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midmul reset busy", {63'b0, busy}, 64'd0);
    check("midmul reset result", {32'b0, alu_out}, 64'd0);
    check("midmul reset zero", {63'b0, zero}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("no done after reset", 64'(done_cnt), 64'd0);
    check("idle after reset", {63'b0, busy}, 64'd0);
    check("result after reset", {32'b0, alu_out}, 64'd0);

    // Back-to-back single ops on the first IDLE cycle.
    applyStimulus(3'b000, 32'hF0, 32'h3C, lat, dcyc);
    checkOutput("b2b and", 32'h30, 1'b0, 1, lat);
    applyStimulus(3'b001, 32'hF0, 32'h3C, lat, dcyc2);
    checkOutput("b2b or", 32'hFC, 1'b0, 1, lat);
    check("b2b done spacing", 64'(dcyc2 - dcyc), 64'd2);

    for (int i = 0; i < 120; i++) begin
      op = ops[$urandom_range(0, 7)];
      x  = pickOperand();
      y  = pickOperand();
      applyStimulus(op, x, y, lat, dcyc);
      checkOutput($sformatf("rand%0d op%0b", i, op), modelResult(op, x, y),
                  modelOverflow(op, x, y), (op == 3'b011) ? W + 1 : 1, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
